// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: single-command blink engine driving active-low LEDs from a prescaler tick.
// Define LED_PERSIST_EN to keep the LED lit in IDLE after a finite sequence completes.
module led_blink_sequencer #(
    parameter int CLK_HZ   = 27000000,
    parameter int TICK_HZ  = 1000,
    parameter int NUM_LEDS = 6,
    parameter int PER_W    = 16,
    parameter int CNT_W    = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [$clog2(NUM_LEDS)-1:0] i_cmd_led,
    input  logic [PER_W-1:0]            i_cmd_period,
    input  logic [CNT_W-1:0]            i_cmd_count,
    input  logic                        i_abort,
    output logic [NUM_LEDS-1:0]         o_led,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_LEDS);
`ifdef LED_PERSIST_EN
    localparam bit PERSIST = 1'b1;
`else
    localparam bit PERSIST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t              r_state;
    logic [PRE_W-1:0]    r_pre;
    logic [PER_W-1:0]    r_tcnt;
    logic [PER_W-1:0]    r_per;
    logic [CNT_W-1:0]    r_rem;
    logic [IDX_W-1:0]    r_sel;
    logic [NUM_LEDS-1:0] r_led_n;
    logic                r_done;

    logic                w_accept;
    logic                w_idx_ok;
    logic                w_tick;
    logic                w_end;
    logic [NUM_LEDS-1:0] w_cmd_n;
    logic [NUM_LEDS-1:0] w_sel_n;

    assign o_cmd_ready = (r_state == IDLE) && !i_abort;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_idx_ok    = {1'b0, i_cmd_led} < (IDX_W + 1)'(NUM_LEDS);
    assign w_tick      = r_pre == PRE_W'(DIV - 1);
    assign w_end       = w_tick && (r_tcnt == r_per - 1'b1);
    assign w_cmd_n     = ~(NUM_LEDS'(1) << i_cmd_led);
    assign w_sel_n     = ~(NUM_LEDS'(1) << r_sel);

    assign o_led  = r_led_n;
    assign o_busy = r_state != IDLE;
    assign o_done = r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_tcnt  <= '0;
            r_per   <= '0;
            r_rem   <= '0;
            r_sel   <= '0;
            r_led_n <= '1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_pre  <= (w_accept || w_tick) ? '0 : r_pre + 1'b1;
            if (r_state == IDLE) begin
                // abort in IDLE only clears a persisted LED
                if (i_abort) begin
                    r_led_n <= '1;
                end else if (w_accept && w_idx_ok) begin
                    r_state <= ON;
                    r_sel   <= i_cmd_led;
                    r_per   <= (i_cmd_period == '0) ? PER_W'(1) : i_cmd_period;
                    r_rem   <= i_cmd_count;
                    r_tcnt  <= '0;
                    r_led_n <= w_cmd_n;
                end else if (w_accept) begin
                    r_done <= 1'b1;
                end
            end else if (i_abort) begin
                r_state <= IDLE;
                r_tcnt  <= '0;
                r_led_n <= '1;
                r_done  <= 1'b1;
            end else if (w_end) begin
                r_tcnt <= '0;
                if (r_state == ON) begin
                    r_state <= OFF;
                    r_led_n <= '1;
                end else if (r_rem == CNT_W'(1)) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                    r_led_n <= PERSIST ? w_sel_n : '1;
                end else begin
                    r_state <= ON;
                    r_led_n <= w_sel_n;
                    if (r_rem != '0) r_rem <= r_rem - 1'b1;
                end
            end else if (w_tick) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb_led_blink_sequencer: directed scenarios with an event scoreboard on LED changes and done pulses.
module tb_led_blink_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  cmd_led = '0;
    logic [15:0] cmd_period = '0;
    logic [7:0]  cmd_count = '0;
    logic        cmd_ready, busy, done;
    logic [5:0]  led;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [5:0] prev_led = 6'h3F;

    typedef struct {
        int         cyc;
        logic [5:0] led;
        logic       done;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;
    ev_t left_e;

`ifdef LED_PERSIST_EN
    localparam bit PERS = 1'b1;
`else
    localparam bit PERS = 1'b0;
`endif

    led_blink_sequencer #(
        .CLK_HZ(1000), .TICK_HZ(100), .NUM_LEDS(6), .PER_W(16), .CNT_W(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_led(cmd_led), .i_cmd_period(cmd_period), .i_cmd_count(cmd_count),
        .i_abort(abort), .o_led(led), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] lit(input int k);
        return ~(6'b1 << k);
    endfunction

    function automatic logic [5:0] idle_after(input int k);
        return PERS ? lit(k) : 6'h3F;
    endfunction

    task automatic push(input int c, input logic [5:0] l, input logic d);
        exp_q.push_back('{c, l, d});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // returns at the negedge of the accept cycle, before the LED reacts
    task automatic send(input logic [2:0] l, input logic [15:0] p, input logic [7:0] n, output int a);
        int w;
        w = 0;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_led    = l;
        cmd_period = p;
        cmd_count  = n;
        #1;
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 300) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready never rose within 300 cycles (cycle %0d)", cyc);
        end
        a = cyc;
        fork
            begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
            end
        join_none
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (led !== prev_led || done !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event: unexpected led=%b done=%b at cycle %0d", led, done, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.led !== led || mon_e.done !== done) begin
                        errors++;
                        $display("FAIL event: got cycle %0d led=%b done=%b, required cycle %0d led=%b done=%b",
                                 cyc, led, done, mon_e.cyc, mon_e.led, mon_e.done);
                    end
                end
            end
            prev_led = led;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, c;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_led", led, 6'h3F);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        prev_led = 6'h3F;
        mon_en   = 1'b1;

        // finite sequence: led 2, 3-tick half period, 2 blinks
        send(3'd2, 16'd3, 8'd2, a);
        push(a + 1, lit(2), 1'b0);
        push(a + 31, 6'h3F, 1'b0);
        push(a + 61, lit(2), 1'b0);
        push(a + 91, 6'h3F, 1'b0);
        push(a + 121, idle_after(2), 1'b1);
        wait_until(a + 125);
        #1;
        chk("s2_ready_back", cmd_ready, 1);
        chk("s2_busy_low", busy, 0);

        // infinite blink aborted during OFF
        send(3'd4, 16'd1, 8'd0, a);
        push(a + 1, lit(4), 1'b0);
        push(a + 11, 6'h3F, 1'b0);
        push(a + 21, lit(4), 1'b0);
        push(a + 31, 6'h3F, 1'b0);
        push(a + 41, lit(4), 1'b0);
        push(a + 51, 6'h3F, 1'b0);
        wait_until(a + 55);
        abort = 1'b1;
        push(a + 56, 6'h3F, 1'b1);
        #1;
        chk("s3_abort_ready", cmd_ready, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("s3_idle_after_abort", busy, 0);

        // abort during ON darkens the LED
        send(3'd2, 16'd1, 8'd3, a);
        push(a + 1, lit(2), 1'b0);
        wait_until(a + 5);
        abort = 1'b1;
        push(a + 6, 6'h3F, 1'b1);
        @(negedge clk);
        abort = 1'b0;

        // command held while busy is taken the first IDLE cycle
        send(3'd1, 16'd1, 8'd1, a);
        push(a + 1, lit(1), 1'b0);
        push(a + 11, 6'h3F, 1'b0);
        push(a + 21, idle_after(1), 1'b1);
        @(negedge clk);
        #1;
        chk("s4_busy", busy, 1);
        chk("s4_ready_low", cmd_ready, 0);
        send(3'd5, 16'd2, 8'd1, b);
        chk("s4_accept_cycle", b - a, 21);
        push(b + 1, lit(5), 1'b0);
        push(b + 21, 6'h3F, 1'b0);
        push(b + 41, idle_after(5), 1'b1);
        wait_until(b + 45);

        // out-of-range index is dropped with a done pulse
        send(3'd7, 16'd3, 8'd3, a);
        push(a + 1, idle_after(5), 1'b1);
        @(negedge clk);
        #1;
        chk("s5_bad_idx_busy", busy, 0);
        // period 0 behaves as period 1
        send(3'd0, 16'd0, 8'd1, a);
        push(a + 1, lit(0), 1'b0);
        push(a + 11, 6'h3F, 1'b0);
        push(a + 21, idle_after(0), 1'b1);
        wait_until(a + 25);

        // abort together with a command in IDLE: abort wins
        @(negedge clk);
        c = cyc;
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_led   = 3'd3;
        if (PERS) push(c + 1, 6'h3F, 1'b0);
        #1;
        chk("idle_abort_ready", cmd_ready, 0);
        @(negedge clk);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);

        // reset mid-ON
        send(3'd3, 16'd2, 8'd0, a);
        push(a + 1, lit(3), 1'b0);
        wait_until(a + 5);
        rst = 1'b1;
        push(a + 6, 6'h3F, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("s6_reset_led", led, 6'h3F);
        chk("s6_reset_busy", busy, 0);
        chk("s6_reset_ready", cmd_ready, 1);
        chk("s6_reset_done", done, 0);

        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) begin
            left_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: required cycle %0d led=%b done=%b never observed",
                     left_e.cyc, left_e.led, left_e.done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
